// File: rtl/usb_buffer_ctrl_if.sv
// Bus bundle between the USB buffer controller, the host, the packet engines
// and the data buffer. The controller uses the slave modport; whatever drives
// the requests uses the master modport.
interface usb_buffer_ctrl_if;
  logic       host_store_req;
  logic       host_get_req;
  logic       tx_start;
  logic [6:0] tx_size;
  logic       tx_get_req;
  logic       rx_store_req;
  logic       rx_done;
  logic       rx_error;
  logic       host_flush;
  logic [6:0] buffer_occupancy;

  logic       store_tx_data;
  logic       store_rx_packet_data;
  logic       get_tx_packet_data;
  logic       get_rx_data;
  logic       flush;
  logic       clear;
  logic       host_busy;
  logic       tx_packet_done;
  logic       rx_data_ready;
  logic       err_overflow;
  logic       err_size;
  logic       err_timeout;
  logic [2:0] state;

  modport slave (
    input  host_store_req, host_get_req, tx_start, tx_size, tx_get_req,
           rx_store_req, rx_done, rx_error, host_flush, buffer_occupancy,
    output store_tx_data, store_rx_packet_data, get_tx_packet_data, get_rx_data,
           flush, clear, host_busy, tx_packet_done, rx_data_ready,
           err_overflow, err_size, err_timeout, state
  );

  modport master (
    output host_store_req, host_get_req, tx_start, tx_size, tx_get_req,
           rx_store_req, rx_done, rx_error, host_flush, buffer_occupancy,
    input  store_tx_data, store_rx_packet_data, get_tx_packet_data, get_rx_data,
           flush, clear, host_busy, tx_packet_done, rx_data_ready,
           err_overflow, err_size, err_timeout, state
  );
endinterface

// File: rtl/usb_buffer_ctrl.sv
// USB endpoint data-buffer controller: sequences host/packet-engine traffic
// into a shared 64-byte buffer.
// Optional feature: define USB_BUFFER_CTRL_TIMEOUT_EN to abort TX_SEND /
// RX_DRAIN after 255 consecutive cycles without a get strobe.
//
// state    | meaning
// IDLE     | buffer free, waiting for first TX or RX byte
// TX_FILL  | host is loading TX bytes, waiting for tx_start
// TX_SEND  | packet engine is pulling the committed TX bytes
// RX_RECV  | RX engine is storing a packet
// RX_DRAIN | received packet ready, host is reading it out
module usb_buffer_ctrl (
  input  logic             clk,
  input  logic             n_rst,
  usb_buffer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_FILL  = 3'd1,
    TX_SEND  = 3'd2,
    RX_RECV  = 3'd3,
    RX_DRAIN = 3'd4
  } state_t;

  localparam logic [6:0] BUF_FULL = 7'd64;

  state_t     state_q, state_nxt;
  logic [6:0] remaining_q, remaining_nxt;
  logic       store_tx, store_rx, get_tx, get_rx, flush_s, clear_s;
  logic       done_set, ovf_set, size_set, tmo_set;
  logic       done_q, ovf_q, size_q, tmo_q;
  logic       tmo_hit;

`ifdef USB_BUFFER_CTRL_TIMEOUT_EN
  // Reload value makes the counter hit zero on the 255th idle cycle.
  localparam logic [7:0] TMO_LOAD = 8'd254;
  logic [7:0] tmo_cnt_q;
  logic       in_wait;

  assign in_wait = (state_q == TX_SEND) || (state_q == RX_DRAIN);
  assign tmo_hit = in_wait && (tmo_cnt_q == 8'd0);

  // Idle down-counter, reloaded on state change or any get strobe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      tmo_cnt_q <= TMO_LOAD;
    else if (!in_wait || (state_nxt != state_q) || get_tx || get_rx)
      tmo_cnt_q <= TMO_LOAD;
    else
      tmo_cnt_q <= tmo_cnt_q - 8'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State, remaining count and registered event pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      remaining_q <= 7'd0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      size_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      remaining_q <= remaining_nxt;
      done_q      <= done_set;
      ovf_q       <= ovf_set;
      size_q      <= size_set;
      tmo_q       <= tmo_set;
    end
  end

  // Next state, buffer strobes and pulse requests; flush beats everything.
  always_comb begin
    state_nxt     = state_q;
    remaining_nxt = remaining_q;
    store_tx      = 1'b0;
    store_rx      = 1'b0;
    get_tx        = 1'b0;
    get_rx        = 1'b0;
    flush_s       = 1'b0;
    clear_s       = 1'b0;
    done_set      = 1'b0;
    ovf_set       = 1'b0;
    size_set      = 1'b0;
    tmo_set       = 1'b0;
    if (bus.host_flush) begin
      flush_s       = 1'b1;
      remaining_nxt = 7'd0;
      state_nxt     = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.rx_store_req) begin
            store_rx  = 1'b1;
            state_nxt = RX_RECV;
          end else if (bus.host_store_req) begin
            store_tx  = 1'b1;
            state_nxt = TX_FILL;
          end
        end
        TX_FILL: begin
          if (bus.host_store_req) begin
            if (bus.buffer_occupancy < BUF_FULL) store_tx = 1'b1;
            else                                 ovf_set  = 1'b1;
          end
          if (bus.tx_start) begin
            if ((bus.tx_size != 7'd0) && (bus.tx_size <= bus.buffer_occupancy)) begin
              remaining_nxt = bus.tx_size;
              state_nxt     = TX_SEND;
            end else begin
              size_set = 1'b1;
            end
          end
        end
        TX_SEND: begin
          if (bus.tx_get_req && (remaining_q != 7'd0)) begin
            get_tx        = 1'b1;
            remaining_nxt = remaining_q - 7'd1;
            if (remaining_q == 7'd1) begin
              done_set  = 1'b1;
              state_nxt = IDLE;
            end
          end else if (tmo_hit) begin
            flush_s       = 1'b1;
            tmo_set       = 1'b1;
            remaining_nxt = 7'd0;
            state_nxt     = IDLE;
          end
        end
        RX_RECV: begin
          if (bus.rx_error) begin
            clear_s   = 1'b1;
            state_nxt = IDLE;
          end else begin
            if (bus.rx_store_req) begin
              if (bus.buffer_occupancy < BUF_FULL) store_rx = 1'b1;
              else                                 ovf_set  = 1'b1;
            end
            if (bus.rx_done)
              state_nxt = ((bus.buffer_occupancy == 7'd0) && !store_rx) ? IDLE : RX_DRAIN;
          end
        end
        RX_DRAIN: begin
          if (bus.host_get_req && (bus.buffer_occupancy != 7'd0)) begin
            get_rx = 1'b1;
            if (bus.buffer_occupancy == 7'd1) state_nxt = IDLE;
          end else if (tmo_hit) begin
            flush_s   = 1'b1;
            tmo_set   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Strobes are combinational, so hold them low while reset is asserted.
  assign bus.store_tx_data        = n_rst & store_tx;
  assign bus.store_rx_packet_data = n_rst & store_rx;
  assign bus.get_tx_packet_data   = n_rst & get_tx;
  assign bus.get_rx_data          = n_rst & get_rx;
  assign bus.flush                = n_rst & flush_s;
  assign bus.clear                = n_rst & clear_s;
  assign bus.host_busy            = (state_q == TX_SEND) || (state_q == RX_RECV) ||
                                    (state_q == RX_DRAIN);
  assign bus.rx_data_ready        = (state_q == RX_DRAIN);
  assign bus.tx_packet_done       = done_q;
  assign bus.err_overflow         = ovf_q;
  assign bus.err_size             = size_q;
  assign bus.state                = state_q;
`ifdef USB_BUFFER_CTRL_TIMEOUT_EN
  assign bus.err_timeout          = tmo_q;
`else
  assign bus.err_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_usb_buffer_ctrl.sv
// Bench for usb_buffer_ctrl: each step drives one cycle of requests, queues
// the outputs that cycle should show, and compares them at the falling edge.
module tb_usb_buffer_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_buffer_ctrl_if bus();

  usb_buffer_ctrl dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // Output vector bit positions: [15:13] state, 12 busy, 11 rx_data_ready.
  localparam logic [15:0] M_STX  = 16'h0400;
  localparam logic [15:0] M_SRX  = 16'h0200;
  localparam logic [15:0] M_GTX  = 16'h0100;
  localparam logic [15:0] M_GRX  = 16'h0080;
  localparam logic [15:0] M_FL   = 16'h0040;
  localparam logic [15:0] M_CL   = 16'h0020;
  localparam logic [15:0] M_DONE = 16'h0010;
  localparam logic [15:0] M_OVF  = 16'h0008;
  localparam logic [15:0] M_SIZE = 16'h0004;
  localparam logic [15:0] M_TMO  = 16'h0002;
  localparam logic [15:0] M_NONE = 16'h0000;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%04h expected=%04h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs();
    return {bus.state, bus.host_busy, bus.rx_data_ready,
            bus.store_tx_data, bus.store_rx_packet_data, bus.get_tx_packet_data,
            bus.get_rx_data, bus.flush, bus.clear, bus.tx_packet_done,
            bus.err_overflow, bus.err_size, bus.err_timeout, 1'b0};
  endfunction

  // Expected vector: busy and ready follow from the state alone.
  function automatic logic [15:0] ev(input logic [2:0] st, input logic [15:0] m);
    logic busy, rdy;
    busy = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
    rdy  = (st == 3'd4);
    return {st, busy, rdy, 11'd0} | m;
  endfunction

  task automatic idle_inputs();
    bus.host_store_req = 1'b0;
    bus.host_get_req   = 1'b0;
    bus.tx_start       = 1'b0;
    bus.tx_size        = 7'd0;
    bus.tx_get_req     = 1'b0;
    bus.rx_store_req   = 1'b0;
    bus.rx_done        = 1'b0;
    bus.rx_error       = 1'b0;
    bus.host_flush     = 1'b0;
  endtask

  // Inputs for this cycle are already set; queue expectation, compare at the
  // falling edge, then move to just past the next rising edge.
  task automatic step(input string tag, input logic [2:0] st, input logic [15:0] m);
    sb_item_t it, got_it;
    it.tag = tag;
    it.exp = ev(st, m);
    sb_q.push_back(it);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got_it = sb_q.pop_front();
      check_eq(got_it.tag, obs(), got_it.exp);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    bus.buffer_occupancy = 7'd0;
    // Outputs stay low in reset even with requests asserted.
    bus.host_store_req = 1'b1;
    bus.rx_store_req   = 1'b1;
    bus.host_flush     = 1'b1;
    #12;
    check_eq("reset_outputs", obs(), 16'h0000);
    idle_inputs();
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    step("first_cycle", 3'd0, M_NONE);

    // Four host writes, commit four bytes, engine pulls four.
    for (int i = 0; i < 4; i++) begin
      bus.host_store_req = 1'b1; bus.buffer_occupancy = 7'(i);
      step($sformatf("tx_store%0d", i), (i == 0) ? 3'd0 : 3'd1, M_STX);
    end
    bus.tx_start = 1'b1; bus.tx_size = 7'd4; bus.buffer_occupancy = 7'd4;
    step("tx_commit4", 3'd1, M_NONE);
    for (int i = 0; i < 4; i++) begin
      bus.tx_get_req = 1'b1; bus.buffer_occupancy = 7'(4 - i);
      step($sformatf("tx_get%0d", i), 3'd2, M_GTX);
    end
    bus.buffer_occupancy = 7'd0;
    step("tx_done_pulse", 3'd0, M_DONE);
    step("tx_done_single", 3'd0, M_NONE);

    // Full buffer during TX fill.
    bus.host_store_req = 1'b1;
    step("fill_enter", 3'd0, M_STX);
    bus.host_store_req = 1'b1; bus.buffer_occupancy = 7'd64;
    step("fill_full_nostore", 3'd1, M_NONE);
    step("overflow_pulse", 3'd1, M_OVF);
    step("overflow_single", 3'd1, M_NONE);

    // Size errors: larger than occupancy and zero.
    bus.buffer_occupancy = 7'd3;
    bus.tx_start = 1'b1; bus.tx_size = 7'd5;
    step("size_too_big", 3'd1, M_NONE);
    bus.tx_start = 1'b1; bus.tx_size = 7'd0;
    step("size_err_pulse5", 3'd1, M_SIZE);
    step("size_err_pulse0", 3'd1, M_SIZE);
    step("size_err_single", 3'd1, M_NONE);

    // Commit exactly occupancy, then flush in the middle of the send.
    bus.tx_start = 1'b1; bus.tx_size = 7'd3;
    step("commit_eq_occ", 3'd1, M_NONE);
    bus.tx_get_req = 1'b1;
    step("send_get_first", 3'd2, M_GTX);
    bus.host_store_req = 1'b1; bus.buffer_occupancy = 7'd2;
    step("busy_store_ignored", 3'd2, M_NONE);
    bus.host_flush = 1'b1; bus.tx_get_req = 1'b1;
    step("flush_mid_send", 3'd2, M_FL);
    bus.buffer_occupancy = 7'd0;
    step("after_flush_idle", 3'd0, M_NONE);

    // RX packet of three bytes, drained by the host.
    for (int i = 0; i < 3; i++) begin
      bus.rx_store_req = 1'b1; bus.buffer_occupancy = 7'(i);
      step($sformatf("rx_store%0d", i), (i == 0) ? 3'd0 : 3'd3, M_SRX);
    end
    bus.rx_done = 1'b1; bus.buffer_occupancy = 7'd3;
    step("rx_done", 3'd3, M_NONE);
    step("drain_wait", 3'd4, M_NONE);
    for (int i = 0; i < 3; i++) begin
      bus.host_get_req = 1'b1; bus.buffer_occupancy = 7'(3 - i);
      step($sformatf("rx_get%0d", i), 3'd4, M_GRX);
    end
    bus.buffer_occupancy = 7'd0;
    step("drain_done_idle", 3'd0, M_NONE);

    // RX beats host in IDLE, overflow while receiving, then abort.
    bus.rx_store_req = 1'b1; bus.host_store_req = 1'b1;
    step("rx_priority", 3'd0, M_SRX);
    bus.rx_store_req = 1'b1; bus.buffer_occupancy = 7'd64;
    step("rx_full_nostore", 3'd3, M_NONE);
    bus.rx_error = 1'b1; bus.rx_done = 1'b1; bus.rx_store_req = 1'b1;
    bus.buffer_occupancy = 7'd1;
    step("rx_error_clear", 3'd3, M_CL | M_OVF);
    bus.buffer_occupancy = 7'd0;
    step("rx_abort_idle", 3'd0, M_NONE);

    // Empty packet: rx_done with nothing stored goes straight back to IDLE.
    bus.rx_store_req = 1'b1;
    step("rx_empty_enter", 3'd0, M_SRX);
    bus.rx_done = 1'b1;
    step("rx_empty_done", 3'd3, M_NONE);
    step("rx_empty_idle", 3'd0, M_NONE);

`ifdef USB_BUFFER_CTRL_TIMEOUT_EN
    bus.host_store_req = 1'b1;
    step("tmo_fill", 3'd0, M_STX);
    bus.tx_start = 1'b1; bus.tx_size = 7'd1; bus.buffer_occupancy = 7'd1;
    step("tmo_commit", 3'd1, M_NONE);
    for (int i = 1; i < 255; i++) step($sformatf("tmo_wait%0d", i), 3'd2, M_NONE);
    step("tmo_flush", 3'd2, M_FL);
    step("tmo_pulse", 3'd0, M_TMO);
`endif

    // Asynchronous reset in the middle of a TX fill.
    bus.host_store_req = 1'b1; bus.buffer_occupancy = 7'd0;
    step("pre_reset_fill", 3'd0, M_STX);
    bus.host_store_req = 1'b1; bus.tx_start = 1'b1; bus.tx_size = 7'd5;
    bus.buffer_occupancy = 7'd2;
    step("pre_reset_size", 3'd1, M_STX);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("async_reset", obs(), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
